// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one L1 D$/memory port between three requesters: frontend fetch,
// backend opload and backend opstore. One requester owns the port from grant
// until the memory reports operation_done. The owner is picked round-robin,
// starting after the previous grant, so a load/store-heavy stream cannot
// starve fetch. A fetch flush either aborts a fetch that has not yet been
// accepted or squashes the completion of one that has.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   fetch/load/store_index_valid   requests from the three channels
//   fetch/load/store_index         19-bit line index, stable while valid
//   store_write_mask/_data         64-bit store byte mask / data
//   fetch_flush                    redirect: abort or squash current fetch
//   *_index_ready                  pulse: owner's request accepted by memory
//   *_operation_done               pulse: owner's transaction completed
//   fetch/load_read_data           read data, valid with the done pulse
//   mem_index_valid/_index         request to memory (from latched request)
//   mem_write_en/_mask/_data       store qualifiers (zero for reads)
//   mem_index_ready                memory accepts request
//   mem_read_data                  memory read data
//   mem_operation_done             memory completion pulse
//   protocol_error                 sticky: unexpected mem_operation_done
// ---------------------------------------------------------------------------
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_index_valid,
    input  logic [18:0] fetch_index,
    input  logic        load_index_valid,
    input  logic [18:0] load_index,
    input  logic        store_index_valid,
    input  logic [18:0] store_index,
    input  logic [63:0] store_write_mask,
    input  logic [63:0] store_write_data,
    input  logic        fetch_flush,
    output logic        fetch_index_ready,
    output logic        load_index_ready,
    output logic        store_index_ready,
    output logic        fetch_operation_done,
    output logic        load_operation_done,
    output logic        store_operation_done,
    output logic [63:0] fetch_read_data,
    output logic [63:0] load_read_data,
    output logic        mem_index_valid,
    output logic [18:0] mem_index,
    output logic        mem_write_en,
    output logic [63:0] mem_write_mask,
    output logic [63:0] mem_write_data,
    input  logic        mem_index_ready,
    input  logic [63:0] mem_read_data,
    input  logic        mem_operation_done,
    output logic        protocol_error
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {CH_FETCH = 2'd0, CH_LOAD = 2'd1, CH_STORE = 2'd2} chan_t;

    state_t      state_reg, state_next;
    chan_t       owner_reg;
    chan_t       last_grant_reg;
    logic        squash_reg, squash_next;
    logic [18:0] index_reg;
    logic        write_en_reg;
    logic [63:0] mask_reg;
    logic [63:0] data_reg;
    logic        protocol_error_reg;

    // ------------------------------------------------------------------
    // Round-robin selection: priority order rotates to start just after
    // the channel granted last time.
    // ------------------------------------------------------------------
    logic [2:0]  valid_vec;
    logic        any_valid;
    chan_t       prio0, prio1, prio2;
    chan_t       grant_ch;
    logic [18:0] grant_index;

    assign valid_vec = {store_index_valid, load_index_valid, fetch_index_valid};
    assign any_valid = |valid_vec;

    always_comb begin
        prio0 = CH_FETCH;
        prio1 = CH_LOAD;
        prio2 = CH_STORE;
        case (last_grant_reg)
            CH_FETCH: begin
                prio0 = CH_LOAD;
                prio1 = CH_STORE;
                prio2 = CH_FETCH;
            end
            CH_LOAD: begin
                prio0 = CH_STORE;
                prio1 = CH_FETCH;
                prio2 = CH_LOAD;
            end
            default: begin
                prio0 = CH_FETCH;
                prio1 = CH_LOAD;
                prio2 = CH_STORE;
            end
        endcase
    end

    always_comb begin
        grant_ch = prio2;
        if (valid_vec[prio0]) begin
            grant_ch = prio0;
        end else if (valid_vec[prio1]) begin
            grant_ch = prio1;
        end
    end

    always_comb begin
        grant_index = fetch_index;
        case (grant_ch)
            CH_LOAD:  grant_index = load_index;
            CH_STORE: grant_index = store_index;
            default:  grant_index = fetch_index;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic accept;         // memory accepted the request this cycle
    logic complete;       // transaction finishes this cycle
    logic perr_set;       // done arrived when none was expected
    logic flush_hit;      // flush aimed at the fetch we currently own
    logic deliver;        // completion is reported to the owner

    assign flush_hit = fetch_flush && (owner_reg == CH_FETCH);

    always_comb begin
        state_next  = state_reg;
        squash_next = squash_reg;
        accept      = 1'b0;
        complete    = 1'b0;
        perr_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_operation_done) begin
                    perr_set = 1'b1;
                end
                if (any_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_index_ready) begin
                    accept = 1'b1;
                    // Already accepted: the memory op must run to completion,
                    // only its done pulse is hidden from fetch.
                    if (flush_hit) begin
                        squash_next = 1'b1;
                    end
                    if (mem_operation_done) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end else begin
                    if (mem_operation_done) begin
                        perr_set = 1'b1;
                    end
                    // Not yet accepted: safe to withdraw the fetch entirely.
                    if (flush_hit) begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT: begin
                if (flush_hit) begin
                    squash_next = 1'b1;
                end
                if (mem_operation_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (complete) begin
            squash_next = 1'b0;
        end
    end

    // A flush arriving in the completion cycle squashes that same completion.
    assign deliver = complete &&
                     !((owner_reg == CH_FETCH) && (squash_reg || fetch_flush));

    // ------------------------------------------------------------------
    // State and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            owner_reg          <= CH_FETCH;
            last_grant_reg     <= CH_STORE;
            squash_reg         <= 1'b0;
            index_reg          <= '0;
            write_en_reg       <= 1'b0;
            mask_reg           <= '0;
            data_reg           <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            squash_reg <= squash_next;
            if (perr_set) begin
                protocol_error_reg <= 1'b1;
            end
            if ((state_reg == IDLE) && any_valid) begin
                owner_reg      <= grant_ch;
                last_grant_reg <= grant_ch;
                index_reg      <= grant_index;
                write_en_reg   <= (grant_ch == CH_STORE);
                mask_reg       <= (grant_ch == CH_STORE) ? store_write_mask : '0;
                data_reg       <= (grant_ch == CH_STORE) ? store_write_data : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel pulse decode; non-owners always see zero.
    // ------------------------------------------------------------------
    logic [2:0] ready_vec;
    logic [2:0] done_vec;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign ready_vec[gi] = accept  && (owner_reg == 2'(gi));
            assign done_vec[gi]  = deliver && (owner_reg == 2'(gi));
        end
    endgenerate

    assign fetch_index_ready    = ready_vec[0];
    assign load_index_ready     = ready_vec[1];
    assign store_index_ready    = ready_vec[2];
    assign fetch_operation_done = done_vec[0];
    assign load_operation_done  = done_vec[1];
    assign store_operation_done = done_vec[2];
    assign fetch_read_data      = done_vec[0] ? mem_read_data : '0;
    assign load_read_data       = done_vec[1] ? mem_read_data : '0;

    assign mem_index_valid = (state_reg == REQ);
    assign mem_index       = index_reg;
    assign mem_write_en    = write_en_reg;
    assign mem_write_mask  = mask_reg;
    assign mem_write_data  = data_reg;
    assign protocol_error  = protocol_error_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change on the falling clock
// edge and outputs are sampled shortly after, well away from the rising edge.
// A small memory-responder task accepts one request, completes it after a
// chosen gap, identifies the owner from the ready pulses and checks the done
// pulse and read data for that owner.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_index_valid, load_index_valid, store_index_valid;
    logic [18:0] fetch_index, load_index, store_index;
    logic [63:0] store_write_mask, store_write_data;
    logic        fetch_flush;
    logic        fetch_index_ready, load_index_ready, store_index_ready;
    logic        fetch_operation_done, load_operation_done, store_operation_done;
    logic [63:0] fetch_read_data, load_read_data;
    logic        mem_index_valid;
    logic [18:0] mem_index;
    logic        mem_write_en;
    logic [63:0] mem_write_mask, mem_write_data;
    logic        mem_index_ready;
    logic [63:0] mem_read_data;
    logic        mem_operation_done;
    logic        protocol_error;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_index_valid    (fetch_index_valid),
        .fetch_index          (fetch_index),
        .load_index_valid     (load_index_valid),
        .load_index           (load_index),
        .store_index_valid    (store_index_valid),
        .store_index          (store_index),
        .store_write_mask     (store_write_mask),
        .store_write_data     (store_write_data),
        .fetch_flush          (fetch_flush),
        .fetch_index_ready    (fetch_index_ready),
        .load_index_ready     (load_index_ready),
        .store_index_ready    (store_index_ready),
        .fetch_operation_done (fetch_operation_done),
        .load_operation_done  (load_operation_done),
        .store_operation_done (store_operation_done),
        .fetch_read_data      (fetch_read_data),
        .load_read_data       (load_read_data),
        .mem_index_valid      (mem_index_valid),
        .mem_index            (mem_index),
        .mem_write_en         (mem_write_en),
        .mem_write_mask       (mem_write_mask),
        .mem_write_data       (mem_write_data),
        .mem_index_ready      (mem_index_ready),
        .mem_read_data        (mem_read_data),
        .mem_operation_done   (mem_operation_done),
        .protocol_error       (protocol_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Request captured by the responder on acceptance.
    logic [18:0] cap_index;
    logic        cap_we;
    logic [63:0] cap_mask;
    logic [63:0] cap_data;

    // Serve one memory transaction: wait (bounded) for mem_index_valid,
    // accept it, signal done gap cycles after acceptance (0 = same cycle).
    // waited counts falling edges until the request showed up.
    task automatic mem_txn(input int gap, input logic [63:0] rdata,
                           output int owner, output int waited);
        logic [2:0] exp_done;
        owner  = -1;
        waited = 0;
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (!mem_index_valid && waited < 12);
        if (!mem_index_valid) begin
            check("grant_timeout", 64'(mem_index_valid), 64'd1);
            return;
        end
        mem_index_ready = 1'b1;
        if (gap == 0) begin
            mem_operation_done = 1'b1;
            mem_read_data      = rdata;
        end
        #1;
        case ({fetch_index_ready, load_index_ready, store_index_ready})
            3'b100:  owner = 0;
            3'b010:  owner = 1;
            3'b001:  owner = 2;
            default: owner = -1;
        endcase
        cap_index = mem_index;
        cap_we    = mem_write_en;
        cap_mask  = mem_write_mask;
        cap_data  = mem_write_data;
        if (gap > 0) begin
            @(negedge clk);
            mem_index_ready = 1'b0;
            repeat (gap - 1) @(negedge clk);
            mem_operation_done = 1'b1;
            mem_read_data      = rdata;
            #1;
        end
        exp_done = (owner == 0) ? 3'b100 : (owner == 1) ? 3'b010 :
                   (owner == 2) ? 3'b001 : 3'b000;
        check("done_pulse", 64'({fetch_operation_done, load_operation_done,
                                  store_operation_done}), 64'(exp_done));
        check("fetch_rdata", fetch_read_data, (owner == 0) ? rdata : 64'd0);
        check("load_rdata", load_read_data, (owner == 1) ? rdata : 64'd0);
        $display("txn owner=%0d index=0x%0h we=%0b mask=0x%0h waited=%0d",
                 owner, cap_index, cap_we, cap_mask, waited);
        @(negedge clk);
        mem_index_ready    = 1'b0;
        mem_operation_done = 1'b0;
        mem_read_data      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, w;
        int exp_seq[6];
        rst                = 1'b1;
        fetch_index_valid  = 1'b0;
        load_index_valid   = 1'b0;
        store_index_valid  = 1'b0;
        fetch_index        = '0;
        load_index         = '0;
        store_index        = '0;
        store_write_mask   = '0;
        store_write_data   = '0;
        fetch_flush        = 1'b0;
        mem_index_ready    = 1'b0;
        mem_read_data      = '0;
        mem_operation_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_valid", 64'(mem_index_valid), 64'd0);
        check("rst_perr", 64'(protocol_error), 64'd0);
        check("rst_mem_index", 64'(mem_index), 64'd0);
        check("rst_we", 64'(mem_write_en), 64'd0);
        rst = 1'b0;

        // Single load with explicit cycle timing.
        @(negedge clk);
        load_index_valid = 1'b1;
        load_index       = 19'h1234;
        #1 check("t1_c0_valid", 64'(mem_index_valid), 64'd0);
        @(negedge clk);
        mem_index_ready  = 1'b1;
        load_index_valid = 1'b0;
        #1;
        check("t1_c1_valid", 64'(mem_index_valid), 64'd1);
        check("t1_c1_index", 64'(mem_index), 64'h1234);
        check("t1_c1_ready", 64'({fetch_index_ready, load_index_ready, store_index_ready}), 64'b010);
        check("t1_c1_we", 64'(mem_write_en), 64'd0);
        @(negedge clk);
        mem_index_ready = 1'b0;
        #1 check("t1_c2_valid", 64'(mem_index_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        mem_operation_done = 1'b1;
        mem_read_data      = 64'hDEADBEEF_CAFEF00D;
        #1;
        check("t1_c4_done", 64'({fetch_operation_done, load_operation_done, store_operation_done}), 64'b010);
        check("t1_c4_rdata", load_read_data, 64'hDEADBEEF_CAFEF00D);
        check("t1_c4_fetch_rdata", fetch_read_data, 64'd0);
        $display("txn owner=1 index=0x1234 we=0 single load");
        @(negedge clk);
        mem_operation_done = 1'b0;
        mem_read_data      = '0;
        #1;
        check("t1_c5_valid", 64'(mem_index_valid), 64'd0);
        check("t1_c5_perr", 64'(protocol_error), 64'd0);

        // All three valid after reset: fetch, load, store, fetch.
        do_reset();
        fetch_index_valid = 1'b1;
        fetch_index       = 19'h100;
        load_index_valid  = 1'b1;
        load_index        = 19'h200;
        store_index_valid = 1'b1;
        store_index       = 19'h300;
        store_write_mask  = 64'hFF00;
        store_write_data  = 64'h55;
        mem_txn(2, 64'h1111, o, w);
        check("t2_owner0", 64'(o), 64'd0);
        check("t2_index0", 64'(cap_index), 64'h100);
        check("t2_mask0", cap_mask, 64'd0);
        mem_txn(2, 64'h2222, o, w);
        check("t2_owner1", 64'(o), 64'd1);
        check("t2_index1", 64'(cap_index), 64'h200);
        mem_txn(2, 64'h3333, o, w);
        check("t2_owner2", 64'(o), 64'd2);
        check("t2_index2", 64'(cap_index), 64'h300);
        check("t2_we2", 64'(cap_we), 64'd1);
        check("t2_mask2", cap_mask, 64'hFF00);
        check("t2_data2", cap_data, 64'h55);
        mem_txn(2, 64'h4444, o, w);
        check("t2_owner3", 64'(o), 64'd0);

        // Everyone keeps requesting, done same cycle as accept: fetch every
        // third grant, a new request two cycles after each completion.
        exp_seq = '{1, 2, 0, 1, 2, 0};
        for (int i = 0; i < 6; i++) begin
            mem_txn(0, 64'(i + 16), o, w);
            check("t3_owner", 64'(o), 64'(exp_seq[i]));
            check("t3_spacing", 64'(w), 64'd1);
        end
        fetch_index_valid = 1'b0;
        load_index_valid  = 1'b0;
        store_index_valid = 1'b0;
        @(negedge clk);

        // Flush of a fetch still waiting for acceptance.
        fetch_index_valid = 1'b1;
        fetch_index       = 19'h111;
        @(negedge clk);
        #1 check("t4_req_valid", 64'(mem_index_valid), 64'd1);
        fetch_flush       = 1'b1;
        fetch_index_valid = 1'b0;
        load_index_valid  = 1'b1;
        load_index        = 19'h222;
        #1 check("t4_no_fready", 64'(fetch_index_ready), 64'd0);
        @(negedge clk);
        fetch_flush = 1'b0;
        #1;
        check("t4_dropped", 64'(mem_index_valid), 64'd0);
        check("t4_no_fdone", 64'(fetch_operation_done), 64'd0);
        mem_txn(1, 64'hABCD, o, w);
        check("t4_load_owner", 64'(o), 64'd1);
        check("t4_load_index", 64'(cap_index), 64'h222);
        load_index_valid = 1'b0;

        // Flush of an accepted fetch while waiting: completion squashed.
        fetch_index_valid = 1'b1;
        fetch_index       = 19'h333;
        @(negedge clk);
        #1 check("t5_req_valid", 64'(mem_index_valid), 64'd1);
        mem_index_ready   = 1'b1;
        fetch_index_valid = 1'b0;
        #1 check("t5_fready", 64'(fetch_index_ready), 64'd1);
        @(negedge clk);
        mem_index_ready = 1'b0;
        fetch_flush     = 1'b1;
        @(negedge clk);
        fetch_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_operation_done = 1'b1;
        mem_read_data      = 64'h1234_5678;
        #1;
        check("t5_squashed_done", 64'(fetch_operation_done), 64'd0);
        check("t5_squashed_rdata", fetch_read_data, 64'd0);
        $display("txn owner=0 index=0x333 we=0 squashed");
        @(negedge clk);
        mem_operation_done = 1'b0;
        mem_read_data      = '0;
        #1;
        check("t5_idle", 64'(mem_index_valid), 64'd0);
        check("t5_perr", 64'(protocol_error), 64'd0);
        fetch_index_valid = 1'b1;
        fetch_index       = 19'h444;
        mem_txn(1, 64'h9999, o, w);
        check("t5_refetch_owner", 64'(o), 64'd0);
        fetch_index_valid = 1'b0;

        // Stray done in IDLE sets the sticky error.
        @(negedge clk);
        mem_operation_done = 1'b1;
        #1 check("t6_perr_before", 64'(protocol_error), 64'd0);
        @(negedge clk);
        mem_operation_done = 1'b0;
        #1 check("t6_perr_set", 64'(protocol_error), 64'd1);
        repeat (3) @(negedge clk);
        #1 check("t6_perr_sticky", 64'(protocol_error), 64'd1);

        // Reset while a load waits for completion.
        load_index_valid = 1'b1;
        load_index       = 19'h555;
        @(negedge clk);
        mem_index_ready  = 1'b1;
        load_index_valid = 1'b0;
        @(negedge clk);
        mem_index_ready = 1'b0;
        #1;
        rst                = 1'b1;
        mem_operation_done = 1'b1;
        #1;
        check("t6_rst_ldone", 64'(load_operation_done), 64'd0);
        check("t6_rst_perr", 64'(protocol_error), 64'd0);
        check("t6_rst_index", 64'(mem_index), 64'd0);
        check("t6_rst_valid", 64'(mem_index_valid), 64'd0);
        $display("txn owner=1 index=0x555 we=0 reset in wait");
        @(negedge clk);
        mem_operation_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("t6_after_rst_valid", 64'(mem_index_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
